// File: rtl/divn_down_counter_pkg.sv
// Shared types and constants for the presettable down-counter / divider.
// Holds the state encoding, the default width and a zero-detect helper.
package divn_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    // Callers zero-extend narrower counts to MAX_WIDTH before asking.
    function automatic logic is_zero(input logic [MAX_WIDTH-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/divn_reload_reg.sv
// Reload register and one-shot flag: captured on pe low, cleared by mr.
// The one-shot flag only exists when DIVN_DOWN_COUNTER_ONESHOT_EN is defined.
module divn_reload_reg
    import divn_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             cp,
    input  logic             mr,
    input  logic             pe,
    input  logic [WIDTH-1:0] d,
`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
    input  logic             os,
`endif
    output logic [WIDTH-1:0] reload,
    output logic             oneshot
);

    always_ff @(posedge cp or negedge mr) begin
        if (!mr)
            reload <= '0;
        else if (!pe)
            reload <= d;
    end

`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
    always_ff @(posedge cp or negedge mr) begin
        if (!mr)
            oneshot <= 1'b0;
        else if (!pe)
            oneshot <= os;
    end
`else
    assign oneshot = 1'b0;
`endif

endmodule

// File: rtl/divn_down_counter.sv
// Presettable down-counter / divide-by-(N+1) with terminal count and zero pulse.
// Define DIVN_DOWN_COUNTER_ONESHOT_EN to add the os port and one-shot (HALT) mode.
module divn_down_counter
    import divn_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             cp,
    input  logic             mr,
    input  logic             pe,
    input  logic [WIDTH-1:0] d,
    input  logic             cep,
    input  logic             cet,
`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
    input  logic             os,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zp,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             zp_nxt;
    logic [WIDTH-1:0] reload;
    logic             oneshot;
    logic             q_zero;

    divn_reload_reg #(.WIDTH(WIDTH)) u_reload (
        .cp      (cp),
        .mr      (mr),
        .pe      (pe),
        .d       (d),
`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
        .os      (os),
`endif
        .reload  (reload),
        .oneshot (oneshot)
    );

    assign q_zero = is_zero(MAX_WIDTH'(q));
    assign busy   = (state == RUN);
    // Combinational so a following stage's cet sees it in the same cycle.
    assign tc     = cet & busy & q_zero;

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        zp_nxt    = 1'b0;
        if (!pe) begin
            q_nxt     = d;
            state_nxt = RUN;
        end else if (state == RUN && cet && cep) begin
            if (!q_zero) begin
                q_nxt = q - WIDTH'(1);
            end else begin
                zp_nxt = 1'b1;
                if (oneshot)
                    state_nxt = HALT;
                else
                    q_nxt = reload;
            end
        end
    end

    always_ff @(posedge cp or negedge mr) begin
        if (!mr) begin
            state <= IDLE;
            q     <= '0;
            zp    <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            zp    <= zp_nxt;
        end
    end

endmodule

// File: tb/tb_divn_down_counter.sv
// Scoreboard bench for divn_down_counter: stimulus pushes expected outputs,
// a negedge monitor pops and compares. Covers single-stage and cascaded use.
module tb_divn_down_counter;

    typedef struct {
        int         id;
        string      nm;
        logic [3:0] q;
        logic       tc;
        logic       zp;
        logic       busy;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic       cp = 1'b0;
    logic       mr, pe, cep, cet, os;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, zp, busy;

    logic       pe_c, cep_c;
    logic [3:0] d_lo, d_hi, q_lo, q_hi;
    logic       tc_lo, tc_hi, zp_lo, zp_hi, busy_lo, busy_hi;

    always #5 cp = ~cp;

    divn_down_counter #(.WIDTH(4)) dut (
        .cp(cp), .mr(mr), .pe(pe), .d(d), .cep(cep), .cet(cet),
`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
        .os(os),
`endif
        .q(q), .tc(tc), .zp(zp), .busy(busy)
    );

    divn_down_counter #(.WIDTH(4)) u_lo (
        .cp(cp), .mr(mr), .pe(pe_c), .d(d_lo), .cep(cep_c), .cet(1'b1),
`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
        .os(1'b0),
`endif
        .q(q_lo), .tc(tc_lo), .zp(zp_lo), .busy(busy_lo)
    );

    divn_down_counter #(.WIDTH(4)) u_hi (
        .cp(cp), .mr(mr), .pe(pe_c), .d(d_hi), .cep(cep_c), .cet(tc_lo),
`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
        .os(1'b0),
`endif
        .q(q_hi), .tc(tc_hi), .zp(zp_hi), .busy(busy_hi)
    );

    function automatic exp_t mk(input int id, input string nm, input logic [3:0] eq,
                                input logic etc, input logic ezp, input logic ebusy);
        exp_t e;
        e.id = id; e.nm = nm; e.q = eq; e.tc = etc; e.zp = ezp; e.busy = ebusy;
        return e;
    endfunction

    // Monitor: compares every queued expectation against the selected instance.
    always @(negedge cp) begin : monitor
        exp_t       e;
        logic [6:0] act, want;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.id)
                1:       act = {q_lo, tc_lo, zp_lo, busy_lo};
                2:       act = {q_hi, tc_hi, zp_hi, busy_hi};
                default: act = {q, tc, zp, busy};
            endcase
            want = {e.q, e.tc, e.zp, e.busy};
            n_chk++;
            if (act !== want) begin
                n_fail++;
                $display("FAIL %s (inst %0d): got q=%0d tc=%b zp=%b busy=%b, want q=%0d tc=%b zp=%b busy=%b",
                         e.nm, e.id, act[6:3], act[2], act[1], act[0],
                         want[6:3], want[2], want[1], want[0]);
            end
        end
    end

    // Drive inputs, let one edge happen, then queue the outputs expected after it.
    task automatic cyc(input logic pe_i, input logic [3:0] d_i, input logic cep_i,
                       input logic cet_i, input logic os_i, input logic [3:0] eq,
                       input logic etc, input logic ezp, input logic ebusy, input string nm);
        pe = pe_i; d = d_i; cep = cep_i; cet = cet_i; os = os_i;
        @(posedge cp); #1;
        sbq.push_back(mk(0, nm, eq, etc, ezp, ebusy));
        @(negedge cp); #1;
    endtask

    task automatic cstep(input logic pe_i, input logic [3:0] dh, input logic [3:0] dl,
                         input logic [3:0] lq, input logic ltc, input logic lzp,
                         input logic [3:0] hq, input logic htc, input logic hzp,
                         input string nm);
        pe_c = pe_i; d_hi = dh; d_lo = dl; cep_c = 1'b1;
        @(posedge cp); #1;
        sbq.push_back(mk(1, {nm, "_lo"}, lq, ltc, lzp, 1'b1));
        sbq.push_back(mk(2, {nm, "_hi"}, hq, htc, hzp, 1'b1));
        @(negedge cp); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        mr = 1'b0; pe = 1'b1; d = 4'd0; cep = 1'b0; cet = 1'b0; os = 1'b0;
        pe_c = 1'b1; cep_c = 1'b0; d_lo = 4'd0; d_hi = 4'd0;
        @(posedge cp); #1;
        sbq.push_back(mk(0, "reset", 4'd0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk(1, "reset_lo", 4'd0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk(2, "reset_hi", 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge cp); #1;
        mr = 1'b1;

        // IDLE ignores enables
        cyc(1, 0, 1, 1, 0, 4'd0, 0, 0, 0, "idle_en_ignored");
        cyc(1, 0, 1, 1, 0, 4'd0, 0, 0, 0, "idle_en_ignored");

        // auto-reload divide by 4
        cyc(0, 3, 1, 1, 0, 4'd3, 0, 0, 1, "load3");
        cyc(1, 3, 1, 1, 0, 4'd2, 0, 0, 1, "ar_2");
        cyc(1, 3, 1, 1, 0, 4'd1, 0, 0, 1, "ar_1");
        cyc(1, 3, 1, 1, 0, 4'd0, 1, 0, 1, "ar_0");
        cyc(1, 3, 1, 1, 0, 4'd3, 0, 1, 1, "ar_reload_zp");
        cyc(1, 3, 1, 1, 0, 4'd2, 0, 0, 1, "ar_2b");
        cyc(1, 3, 1, 1, 0, 4'd1, 0, 0, 1, "ar_1b");
        cyc(1, 3, 1, 1, 0, 4'd0, 1, 0, 1, "ar_0b");
        cyc(1, 3, 1, 1, 0, 4'd3, 0, 1, 1, "ar_reload_zp_b");
        cyc(1, 3, 1, 1, 0, 4'd2, 0, 0, 1, "gate_pre");

        // cep low freezes the count
        for (int i = 0; i < 5; i++)
            cyc(1, 3, 0, 1, 0, 4'd2, 0, 0, 1, "cep_hold");
        cyc(1, 3, 1, 1, 0, 4'd1, 0, 0, 1, "cep_resume");
        cyc(1, 3, 1, 1, 0, 4'd0, 1, 0, 1, "cep_to_zero");
        // cet low at zero: no reload, tc forced low
        cyc(1, 3, 1, 0, 0, 4'd0, 0, 0, 1, "cet_low_noreload");
        cyc(1, 3, 1, 0, 0, 4'd0, 0, 0, 1, "cet_low_noreload");
        cyc(1, 3, 0, 1, 0, 4'd0, 1, 0, 1, "cep_low_tc_kept");

        // load beats the zero reload
        cyc(0, 7, 1, 1, 0, 4'd7, 0, 0, 1, "load_beats_zero");
        cyc(1, 7, 1, 1, 0, 4'd6, 0, 0, 1, "after_load");

        // asynchronous reset mid-count
        cyc(0, 9, 1, 1, 0, 4'd9, 0, 0, 1, "load9");
        cyc(1, 9, 1, 1, 0, 4'd8, 0, 0, 1, "run_8");
        cyc(1, 9, 1, 1, 0, 4'd7, 0, 0, 1, "run_7");
        cyc(1, 9, 1, 1, 0, 4'd6, 0, 0, 1, "run_6");
        @(posedge cp); #1;
        mr = 1'b0;
        #1;
        sbq.push_back(mk(0, "async_reset", 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge cp); #1;
        mr = 1'b1;
        cyc(1, 9, 1, 1, 0, 4'd0, 0, 0, 0, "post_rst_idle");
        cyc(1, 9, 1, 1, 0, 4'd0, 0, 0, 0, "post_rst_idle");

        // d = 0: zp every cycle, tc held high
        cyc(0, 0, 1, 1, 0, 4'd0, 1, 0, 1, "d0_load");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 1, 1, 0, 4'd0, 1, 1, 1, "d0_zp");

        // d = all-ones: period 16
        cyc(0, 15, 1, 1, 0, 4'd15, 0, 0, 1, "d15_load");
        for (int i = 1; i <= 15; i++)
            cyc(1, 15, 1, 1, 0, 4'(15 - i), (i == 15), 0, 1, "d15_count");
        cyc(1, 15, 1, 1, 0, 4'd15, 0, 1, 1, "d15_reload_zp");

`ifdef DIVN_DOWN_COUNTER_ONESHOT_EN
        cyc(0, 2, 1, 1, 1, 4'd2, 0, 0, 1, "os_load");
        cyc(1, 2, 1, 1, 0, 4'd1, 0, 0, 1, "os_1");
        cyc(1, 2, 1, 1, 0, 4'd0, 1, 0, 1, "os_0");
        cyc(1, 2, 1, 1, 0, 4'd0, 0, 1, 0, "os_halt");
        cyc(1, 2, 1, 1, 0, 4'd0, 0, 0, 0, "os_hold");
        cyc(1, 2, 1, 1, 0, 4'd0, 0, 0, 0, "os_hold");
        cyc(0, 2, 1, 1, 0, 4'd2, 0, 0, 1, "os_restart");
        cyc(1, 2, 1, 1, 0, 4'd1, 0, 0, 1, "os_restart_run");
`endif

        // cascade: hi=0, lo=1
        pe = 1'b1;
        cstep(0, 4'd0, 4'd1, 4'd1, 0, 0, 4'd0, 0, 0, "casc_load01");
        cstep(1, 4'd0, 4'd1, 4'd0, 1, 0, 4'd0, 1, 0, "casc_zero");
        cstep(1, 4'd0, 4'd1, 4'd1, 0, 1, 4'd0, 0, 1, "casc_wrap");
        cstep(1, 4'd0, 4'd1, 4'd0, 1, 0, 4'd0, 1, 0, "casc_zero2");
        // cascade: hi=2, lo=0
        cstep(0, 4'd2, 4'd0, 4'd0, 1, 0, 4'd2, 0, 0, "casc_load20");
        cstep(1, 4'd2, 4'd0, 4'd0, 1, 1, 4'd1, 0, 0, "casc_hi1");
        cstep(1, 4'd2, 4'd0, 4'd0, 1, 1, 4'd0, 1, 0, "casc_hi0");
        cstep(1, 4'd2, 4'd0, 4'd0, 1, 1, 4'd2, 0, 1, "casc_hi_reload");

        @(negedge cp); #1;
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/divn_down_counter.md
Name: divn_down_counter

Overview:
- Presettable synchronous down-counter and programmable divider. It is the count-down counterpart of the board's 4-bit up-counters.
- Loads a divisor, decrements while enabled, and flags the terminal count on reaching zero. At zero it either reloads (divide-by-(N+1)) or halts (one-shot).
- Used for baud/video timing dividers and cascadable delay timers in the board simulation.

Parameters:
- WIDTH, 4, width of the counter, the preset and the reload register; legal range 2..16.

Ports:
- cp  input  1  clock; all state changes on rising edge.
- mr  input  1  master reset, asynchronous, active-low.
- pe  input  1  parallel enable, synchronous, active-low; loads d.
- d  input  WIDTH  preset/divisor value.
- cep  input  1  count enable (parallel).
- cet  input  1  count enable (trickle/cascade); also gates tc.
- os  input  1  one-shot select, sampled on load (present only with the macro).
- q  output  WIDTH  current count.
- tc  output  1  terminal count (borrow), combinational.
- zp  output  1  registered one-cycle zero pulse.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (mr low, asynchronous): q=0, reload register=0, one-shot flag=0, state=IDLE, zp=0, busy=0, tc=0. Reset wins over every other input, including mid-count; release is synchronous to the next cp edge.
- States: IDLE, RUN, HALT. busy = (state==RUN).
- Priority at each cp edge: pe low > count step > hold.
- Load (pe low, any state):
  - q<=d; reload<=d; one-shot flag<=os; state<=RUN; zp<=0.
  - Load beats a simultaneous count step and a simultaneous zero event; no zp for that edge.
- Count step: state==RUN and cet=1 and cep=1.
  - q!=0: q<=q-1; zp<=0.
  - q==0, one-shot flag=0: q<=reload; zp<=1; stay in RUN.
  - q==0, one-shot flag=1: q holds 0; zp<=1; state<=HALT.
- Otherwise hold q. zp<=0, so zp is never high for more than one cycle.
- IDLE and HALT: q holds; cep/cet are ignored; only pe leaves these states.
- tc = cet & busy & (q==0). It is combinational and follows cet in the same cycle, so cascading cet of the next stage from tc gives a synchronous multi-stage counter.
- Period in auto-reload mode with cep=cet=1 continuously: d+1 cycles between zp pulses.
  - d=0 gives zp every cycle and tc held high.
  - d=all-ones gives a period of 2^WIDTH.
- No wrap below zero ever occurs: zero always reloads or halts.
- cep low in RUN freezes q and tc and suppresses zp. cet low additionally forces tc=0.

Optional Feature:
- Macro DIVN_DOWN_COUNTER_ONESHOT_EN.
- Defined: the os port exists; a load with os=1 selects one-shot (RUN->HALT at zero).
- Undefined: the os port is absent, the one-shot flag is tied 0, the HALT state is unreachable, and the block is pure auto-reload.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package:
  - State enum (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
  - Default WIDTH constant.
  - A zero constant helper.
- One sub-module is natural: divn_reload_reg, holding the reload register and the one-shot flag, with load on pe low and clear on mr.
- The counter and FSM stay in the top module.

Test Plan:
- Reset mid-count: load d=4'd9, run 3 cycles, pulse mr low between edges -> q=0, busy=0, tc=0, zp=0 immediately; after release q stays 0 until pe.
- Auto-reload divide: WIDTH=4, load d=4'd3, cep=cet=1 -> q sequence 3,2,1,0,3,2,...; zp high for exactly 1 cycle every 4 cycles, in the cycle after q==0; tc high in each q==0 cycle.
- Enable gating: with q=2, drop cep for 5 cycles -> q holds 2 and zp stays 0. Drop cet at q=0 -> tc=0 immediately and no reload.
- Load priority: pe low on the same edge that q==0 would reload, with d=4'd7 -> q=7, zp=0, state RUN.
- Cascade: two instances, low tc -> high cet, both cep=1, load 8'h00/8'h01 (hi,lo) as 4'd0/4'd1 -> combined 8-bit count reaches 0 after 1 cycle; high-stage tc high only while both stages are 0. Repeat with hi=4'd2, lo=4'd0 -> hi decrements only on cycles where lo tc=1.
- One-shot (macro defined): load d=4'd2, os=1 -> q 2,1,0; zp pulses once; state HALT, busy=0; further enables leave q=0; a new pe low restarts the count.
